// File: rtl/fp_mul_result_stage.sv
// Result stage behind the combinational FP multiplier: special-case override, flags, 2-entry skid.
// One-cycle latency when the output register is free; in_ready is a flop and drops only when both entries hold data.
module fp_mul_result_stage #(
   parameter int N  = 23,
   parameter int M  = 8,
   parameter int CW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N+M:0]     op_a,
   input  logic [N+M:0]     op_b,
   input  logic [N+M:0]     prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N+M:0]     out_data,
   output logic [2:0]       out_flags,
   output logic [CW-1:0]    exc_count
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   localparam logic [M+1:0] BIAS    = (M+2)'(2**(M-1) - 1);
   localparam logic [M+1:0] EXP_TOP = (M+2)'(2**M - 1);
   localparam logic [N+M:0] QNAN    = {1'b0, {M{1'b1}}, 1'b1, {(N-1){1'b0}}};

   // operand fields
   logic           sa, sb, s;
   logic [M-1:0]   ea, eb, ep;
   logic [N-1:0]   fa, fb;
   logic           a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   // exponent check for the ordinary path
   logic [M+1:0]   exp_raw;
   logic [M+1:0]   exp_fin;
   logic [M-1:0]   exp_diff;
   logic           norm;
   logic           exp_over, exp_under;

   logic [N+M:0]   res_data;
   logic [2:0]     res_flags;

   // skid buffer state
   logic [1:0]     state, state_nxt;
   logic [N+M:0]   skid_data;
   logic [2:0]     skid_flags;
   logic           in_xfer, out_xfer;
   logic           ld_out, ld_skid, skid_to_out;

   always_comb begin
      sa = op_a[N+M];
      sb = op_b[N+M];
      s  = sa ^ sb;
      ea = op_a[N+M-1:N];
      eb = op_b[N+M-1:N];
      ep = prod[N+M-1:N];
      fa = op_a[N-1:0];
      fb = op_b[N-1:0];

      a_nan  = (&ea) && (|fa);
      b_nan  = (&eb) && (|fb);
      a_inf  = (&ea) && !(|fa);
      b_inf  = (&eb) && !(|fb);
      a_zero = (ea == '0);
      b_zero = (eb == '0);
   end

   always_comb begin
      exp_raw   = {2'b00, ea} + {2'b00, eb} - BIAS;
      // the multiplier may have renormalised the mantissa and bumped the exponent by one
      exp_diff  = ep - exp_raw[M-1:0];
      norm      = (exp_diff == M'(1));
      exp_fin   = exp_raw + {{(M+1){1'b0}}, norm};
      exp_over  = $signed(exp_fin) >= $signed(EXP_TOP);
      exp_under = $signed(exp_fin) <= $signed({(M+2){1'b0}});
   end

   always_comb begin
      res_data  = prod;
      res_flags = 3'b000;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         res_data  = QNAN;
         res_flags = 3'b100;
      end else if (a_inf || b_inf) begin
         res_data  = {s, {M{1'b1}}, {N{1'b0}}};
      end else if (a_zero || b_zero) begin
         res_data  = {s, {M{1'b0}}, {N{1'b0}}};
      end else if (exp_over) begin
         res_data  = {s, {M{1'b1}}, {N{1'b0}}};
         res_flags = 3'b010;
      end else if (exp_under) begin
         res_data  = {s, {M{1'b0}}, {N{1'b0}}};
         res_flags = 3'b001;
      end
   end

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      state_nxt   = state;
      ld_out      = 1'b0;
      ld_skid     = 1'b0;
      skid_to_out = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               state_nxt = ONE;
               ld_out    = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               ld_out    = 1'b1;
            end else if (in_xfer) begin
               state_nxt = TWO;
               ld_skid   = 1'b1;
            end else if (out_xfer) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (out_xfer) begin
               state_nxt   = ONE;
               skid_to_out = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_flags  <= 3'b000;
         skid_data  <= '0;
         skid_flags <= 3'b000;
         exc_count  <= '0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != TWO);
         out_valid <= (state_nxt != EMPTY);
         if (ld_out) begin
            out_data  <= res_data;
            out_flags <= res_flags;
         end else if (skid_to_out) begin
            out_data  <= skid_data;
            out_flags <= skid_flags;
         end
         if (ld_skid) begin
            skid_data  <= res_data;
            skid_flags <= res_flags;
         end
         if (in_xfer && (|res_flags) && !(&exc_count))
            exc_count <= exc_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Directed bench for fp_mul_result_stage: vector table plus backpressure, mid-run reset and counter saturation.
module tb_fp_mul_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] op_a, op_b, prod, out_data;
   logic [2:0]  out_flags;
   logic [15:0] exc_count;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [31:0] s_op_a, s_op_b, s_prod, s_out_data;
   logic [2:0]  s_out_flags;
   logic [1:0]  s_exc_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fp_mul_result_stage #(.N(23), .M(8), .CW(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .prod(prod), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
      .exc_count(exc_count)
   );

   fp_mul_result_stage #(.N(23), .M(8), .CW(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .op_a(s_op_a), .op_b(s_op_b), .prod(s_prod), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_data(s_out_data), .out_flags(s_out_flags),
      .exc_count(s_exc_count)
   );

   typedef struct {
      string       name;
      logic [31:0] a, b, p, d;
      logic [2:0]  f;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // present one vector, check it on the output one cycle later, then let it drain
   task automatic send(input vec_t v);
      in_valid = 1'b1;
      op_a = v.a; op_b = v.b; prod = v.p;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({v.name, "_vld"}, {31'd0, out_valid}, 32'd1);
      chk({v.name, "_dat"}, out_data, v.d);
      chk({v.name, "_flg"}, {29'd0, out_flags}, {29'd0, v.f});
      @(posedge clk); #1;
   endtask

   initial begin
      int   exc_model;
      int   sat_model;
      int   k, j;
      int   bp[4];
      logic ixf, oxf;

      tv[0]  = '{"mul_2x3",      32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 3'b000};
      tv[1]  = '{"inf_x_zero",   32'h7F800000, 32'h00000000, 32'h12345678, 32'h7FC00000, 3'b100};
      tv[2]  = '{"ovf_pos",      32'h7F000000, 32'h7F000000, 32'h00000000, 32'h7F800000, 3'b010};
      tv[3]  = '{"ovf_neg",      32'hFF000000, 32'h7F000000, 32'h00000000, 32'hFF800000, 3'b010};
      tv[4]  = '{"unf_neg",      32'h00800000, 32'h80800000, 32'h00000000, 32'h80000000, 3'b001};
      tv[5]  = '{"nan_x_one",    32'h7F800001, 32'h3F800000, 32'h00000000, 32'h7FC00000, 3'b100};
      tv[6]  = '{"inf_x_neg",    32'h7F800000, 32'hC0000000, 32'h00000000, 32'hFF800000, 3'b000};
      tv[7]  = '{"zero_x_neg",   32'h00000000, 32'hC0400000, 32'h00000000, 32'h80000000, 3'b000};
      tv[8]  = '{"norm_1p5sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h40100000, 3'b000};
      tv[9]  = '{"denorm_flush", 32'h00400000, 32'h3F800000, 32'h00200000, 32'h00000000, 3'b000};
      tv[10] = '{"ovf_edge",     32'h5F800000, 32'h5F800000, 32'h7F800000, 32'h7F800000, 3'b010};
      tv[11] = '{"max_exp_ok",   32'h5F800000, 32'h5F000000, 32'h7F000000, 32'h7F000000, 3'b000};
      tv[12] = '{"unf_edge",     32'h1F800000, 32'h20000000, 32'h00000000, 32'h00000000, 3'b001};
      tv[13] = '{"min_exp_ok",   32'h20000000, 32'h20000000, 32'h00800000, 32'h00800000, 3'b000};
      tv[14] = '{"norm_rescue",  32'h1FC00000, 32'h20400000, 32'h00900000, 32'h00900000, 3'b000};
      tv[15] = '{"nan_x_zero",   32'h00000000, 32'hFFC00000, 32'h00000000, 32'h7FC00000, 3'b100};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1;
      op_a = '0; op_b = '0; prod = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b1;
      s_op_a = 32'h7F800000; s_op_b = 32'h00000000; s_prod = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
      chk("rst_exc_count", {16'd0, exc_count}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

      exc_model = 0;
      for (int i = 0; i < 16; i++) begin
         send(tv[i]);
         if (tv[i].f != 3'b000) exc_model++;
         chk({tv[i].name, "_cnt"}, {16'd0, exc_count}, exc_model);
      end
      chk("drained_out_valid", {31'd0, out_valid}, 32'd0);

      // four back-to-back inputs against a consumer stalled for three cycles
      bp = '{0, 1, 8, 4};
      k = 0; j = 0;
      for (int cyc = 0; cyc < 30 && j < 4; cyc++) begin
         in_valid  = (k < 4);
         if (k < 4) begin
            op_a = tv[bp[k]].a; op_b = tv[bp[k]].b; prod = tv[bp[k]].p;
         end
         out_ready = (cyc >= 3);
         @(negedge clk);
         ixf = in_valid && in_ready;
         oxf = out_valid && out_ready;
         if (cyc == 2) begin
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_accepted_two", k, 2);
            chk("bp_stall_hold",   out_data, tv[bp[0]].d);
         end
         if (oxf) begin
            chk($sformatf("bp_out%0d_dat", j), out_data, tv[bp[j]].d);
            chk($sformatf("bp_out%0d_flg", j), {29'd0, out_flags}, {29'd0, tv[bp[j]].f});
            j++;
         end
         @(posedge clk); #1;
         if (ixf) k++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_in",  k, 4);
      chk("bp_all_out", j, 4);
      exc_model += 2;
      chk("bp_cnt", {16'd0, exc_count}, exc_model);

      // fill both entries, then reset while a flagged input is offered
      out_ready = 1'b0;
      in_valid = 1'b1;
      op_a = tv[0].a; op_b = tv[0].b; prod = tv[0].p;
      @(posedge clk); #1;
      op_a = tv[8].a; op_b = tv[8].b; prod = tv[8].p;
      @(posedge clk); #1;
      chk("two_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      op_a = tv[1].a; op_b = tv[1].b; prod = tv[1].p;
      @(posedge clk); #1;
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_exc_count", {16'd0, exc_count}, 32'd0);
      chk("mrst_in_ready",  {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("mrst_no_count",   {16'd0, exc_count}, 32'd0);
      chk("mrst_still_empty", {31'd0, out_valid}, 32'd0);

      // two-bit counter must stick at 3
      sat_model = 0;
      for (int i = 0; i < 5; i++) begin
         s_in_valid = 1'b1;
         @(posedge clk); #1;
         s_in_valid = 1'b0;
         sat_model = (sat_model < 3) ? sat_model + 1 : 3;
         chk($sformatf("sat_cnt%0d", i), {30'd0, s_exc_count}, sat_model);
         chk($sformatf("sat_dat%0d", i), s_out_data, 32'h7FC00000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
